// File: rtl/axi4_to_ahb_pkg.sv
// Shared types, constants and helpers for the AXI4-to-AHB-Lite bridge.
package axi4_to_ahb_pkg;

  typedef logic [2:0] axi2ahb_state_t;

  localparam axi2ahb_state_t ST_IDLE    = 3'd0;
  localparam axi2ahb_state_t ST_WR_ADDR = 3'd1;
  localparam axi2ahb_state_t ST_WR_DATA = 3'd2;
  localparam axi2ahb_state_t ST_RD_ADDR = 3'd3;
  localparam axi2ahb_state_t ST_RD_DATA = 3'd4;
  localparam axi2ahb_state_t ST_WR_RESP = 3'd5;
  localparam axi2ahb_state_t ST_RD_RESP = 3'd6;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Anything wider than a doubleword collapses to a doubleword on the 64-bit bus.
  function automatic logic [2:0] hsize_map(input logic [2:0] axsize);
    hsize_map = axsize[2] ? 3'b011 : {1'b0, axsize[1:0]};
  endfunction

  function automatic logic misaligned(input logic [2:0] hsize, input logic [2:0] addr_lo);
    case (hsize)
      3'b001:  misaligned = addr_lo[0];
      3'b010:  misaligned = |addr_lo[1:0];
      3'b011:  misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi4_to_ahb_cmdbuf.sv
// Single-entry command/response holding register for the bridge: command fields are
// loaded on acceptance, read data and the error flag are filled in during the data phase.
module axi4_to_ahb_cmdbuf #(
  parameter int TAG = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           load_i,
  input  logic [31:0]    addr_i,
  input  logic [2:0]     size_i,
  input  logic           write_i,
  input  logic [TAG-1:0] id_i,
  input  logic [63:0]    wdata_i,
  input  logic           err_i,
  input  logic           rdata_ld_i,
  input  logic [63:0]    rdata_i,
  input  logic           err_set_i,
  output logic [31:0]    addr_o,
  output logic [2:0]     size_o,
  output logic           write_o,
  output logic [TAG-1:0] id_o,
  output logic [63:0]    wdata_o,
  output logic [63:0]    rdata_o,
  output logic           err_o
);

  logic [31:0]    addr_q;
  logic [2:0]     size_q;
  logic           write_q;
  logic [TAG-1:0] id_q;
  logic [63:0]    wdata_q;
  logic [63:0]    rdata_q;
  logic           err_q;

  // A load clears read data so a rejected read returns zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= 32'd0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      id_q    <= {TAG{1'b0}};
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else if (en_i && load_i) begin
      addr_q  <= addr_i;
      size_q  <= size_i;
      write_q <= write_i;
      id_q    <= id_i;
      wdata_q <= wdata_i;
      rdata_q <= 64'd0;
      err_q   <= err_i;
    end else if (en_i) begin
      rdata_q <= rdata_ld_i ? rdata_i : rdata_q;
      err_q   <= err_q | err_set_i;
    end else begin
      err_q   <= err_q;
    end
  end

  assign addr_o  = addr_q;
  assign size_o  = size_q;
  assign write_o = write_q;
  assign id_o    = id_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: rtl/axi4_to_ahb.sv
// AXI4 slave to AHB-Lite master bridge: one single-beat 64-bit transfer in flight at a time.
// Build option AXI4_TO_AHB_ALIGN_CHK_EN rejects misaligned commands with SLVERR before AHB.
module axi4_to_ahb
  import axi4_to_ahb_pkg::*;
#(
  parameter int TAG = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bus_clk_en,
  input  logic           axi_awvalid,
  output logic           axi_awready,
  input  logic [TAG-1:0] axi_awid,
  input  logic [31:0]    axi_awaddr,
  input  logic [2:0]     axi_awsize,
  input  logic           axi_wvalid,
  output logic           axi_wready,
  input  logic [63:0]    axi_wdata,
  input  logic [7:0]     axi_wstrb,
  output logic           axi_bvalid,
  input  logic           axi_bready,
  output logic [1:0]     axi_bresp,
  output logic [TAG-1:0] axi_bid,
  input  logic           axi_arvalid,
  output logic           axi_arready,
  input  logic [TAG-1:0] axi_arid,
  input  logic [31:0]    axi_araddr,
  input  logic [2:0]     axi_arsize,
  output logic           axi_rvalid,
  input  logic           axi_rready,
  output logic [TAG-1:0] axi_rid,
  output logic [63:0]    axi_rdata,
  output logic [1:0]     axi_rresp,
  output logic           axi_rlast,
  output logic [31:0]    ahb_haddr,
  output logic [2:0]     ahb_hsize,
  output logic [1:0]     ahb_htrans,
  output logic           ahb_hwrite,
  output logic [63:0]    ahb_hwdata,
  output logic [2:0]     ahb_hburst,
  output logic [3:0]     ahb_hprot,
  output logic           ahb_hmastlock,
  input  logic [63:0]    ahb_hrdata,
  input  logic           ahb_hready,
  input  logic           ahb_hresp
);

`ifdef AXI4_TO_AHB_ALIGN_CHK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  localparam logic ALIGN_CHK = 1'b0;
`endif

  axi2ahb_state_t state_q, state_d;
  logic           aw_acc_s, ar_acc_s, load_s, ld_write_s, ld_err_s, rdata_ld_s, err_set_s;
  logic [2:0]     aw_size_s, ar_size_s, ld_size_s;
  logic           aw_mis_s, ar_mis_s;
  logic [31:0]    ld_addr_s;
  logic [TAG-1:0] ld_id_s;
  logic [31:0]    cb_addr_s;
  logic [2:0]     cb_size_s;
  logic           cb_write_s, cb_err_s;
  logic [TAG-1:0] cb_id_s;
  logic [63:0]    cb_wdata_s, cb_rdata_s;
  logic           unused_wstrb_s;

  // Byte strobes are not forwarded; the slave works from haddr/hsize.
  assign unused_wstrb_s = ^axi_wstrb;

  assign aw_size_s = hsize_map(axi_awsize);
  assign ar_size_s = hsize_map(axi_arsize);
  assign aw_mis_s  = ALIGN_CHK & misaligned(aw_size_s, axi_awaddr[2:0]);
  assign ar_mis_s  = ALIGN_CHK & misaligned(ar_size_s, axi_araddr[2:0]);

  assign aw_acc_s  = (state_q == ST_IDLE) & axi_awvalid & axi_wvalid;
  assign ar_acc_s  = (state_q == ST_IDLE) & ~(axi_awvalid & axi_wvalid) & axi_arvalid;
  assign err_set_s = ((state_q == ST_WR_DATA) | (state_q == ST_RD_DATA)) & ahb_hresp;

  // Next-state and command-load selection.
  always_comb begin
    state_d    = state_q;
    load_s     = 1'b0;
    ld_write_s = 1'b0;
    ld_err_s   = 1'b0;
    ld_addr_s  = axi_awaddr;
    ld_size_s  = aw_size_s;
    ld_id_s    = axi_awid;
    rdata_ld_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aw_acc_s) begin
          load_s     = 1'b1;
          ld_write_s = 1'b1;
          ld_err_s   = aw_mis_s;
          state_d    = aw_mis_s ? ST_WR_RESP : ST_WR_ADDR;
        end else if (ar_acc_s) begin
          load_s     = 1'b1;
          ld_err_s   = ar_mis_s;
          ld_addr_s  = axi_araddr;
          ld_size_s  = ar_size_s;
          ld_id_s    = axi_arid;
          state_d    = ar_mis_s ? ST_RD_RESP : ST_RD_ADDR;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        if (ahb_hready) state_d = ST_WR_DATA;
        else            state_d = ST_WR_ADDR;
      end
      ST_WR_DATA: begin
        if (ahb_hready) state_d = ST_WR_RESP;
        else            state_d = ST_WR_DATA;
      end
      ST_RD_ADDR: begin
        if (ahb_hready) state_d = ST_RD_DATA;
        else            state_d = ST_RD_ADDR;
      end
      ST_RD_DATA: begin
        if (ahb_hready) begin
          rdata_ld_s = 1'b1;
          state_d    = ST_RD_RESP;
        end else begin
          state_d    = ST_RD_DATA;
        end
      end
      ST_WR_RESP: begin
        if (axi_bready) state_d = ST_IDLE;
        else            state_d = ST_WR_RESP;
      end
      ST_RD_RESP: begin
        if (axi_rready) state_d = ST_IDLE;
        else            state_d = ST_RD_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State only advances on qualified AHB cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (bus_clk_en) begin
      state_q <= state_d;
    end else begin
      state_q <= state_q;
    end
  end

  axi4_to_ahb_cmdbuf #(.TAG(TAG)) u_cmdbuf (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (bus_clk_en),
    .load_i     (load_s),
    .addr_i     (ld_addr_s),
    .size_i     (ld_size_s),
    .write_i    (ld_write_s),
    .id_i       (ld_id_s),
    .wdata_i    (axi_wdata),
    .err_i      (ld_err_s),
    .rdata_ld_i (rdata_ld_s),
    .rdata_i    (ahb_hrdata),
    .err_set_i  (err_set_s),
    .addr_o     (cb_addr_s),
    .size_o     (cb_size_s),
    .write_o    (cb_write_s),
    .id_o       (cb_id_s),
    .wdata_o    (cb_wdata_s),
    .rdata_o    (cb_rdata_s),
    .err_o      (cb_err_s)
  );

  assign axi_awready = aw_acc_s & bus_clk_en;
  assign axi_wready  = aw_acc_s & bus_clk_en;
  assign axi_arready = ar_acc_s & bus_clk_en;

  assign axi_bvalid  = (state_q == ST_WR_RESP);
  assign axi_bresp   = cb_err_s ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_bid     = cb_id_s;
  assign axi_rvalid  = (state_q == ST_RD_RESP);
  assign axi_rresp   = cb_err_s ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_rid     = cb_id_s;
  assign axi_rdata   = cb_rdata_s;
  assign axi_rlast   = 1'b1;

  assign ahb_htrans    = ((state_q == ST_WR_ADDR) | (state_q == ST_RD_ADDR)) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb_haddr     = cb_addr_s;
  assign ahb_hsize     = cb_size_s;
  assign ahb_hwrite    = cb_write_s;
  assign ahb_hwdata    = cb_wdata_s;
  assign ahb_hburst    = 3'b000;
  assign ahb_hprot     = 4'b0011;
  assign ahb_hmastlock = 1'b0;

endmodule

// File: tb/tb_axi4_to_ahb.sv
// Directed plus randomized bench for axi4_to_ahb; the bench plays AXI master and AHB slave.
module tb_axi4_to_ahb;
  localparam int TAG = 1;
`ifdef AXI4_TO_AHB_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, bus_clk_en;
  logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic [TAG-1:0] axi_awid, axi_bid, axi_arid, axi_rid;
  logic [31:0] axi_awaddr, axi_araddr, ahb_haddr;
  logic [2:0]  axi_awsize, axi_arsize, ahb_hsize, ahb_hburst;
  logic [63:0] axi_wdata, axi_rdata, ahb_hwdata, ahb_hrdata;
  logic [7:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp, ahb_htrans;
  logic [3:0]  ahb_hprot;
  logic        ahb_hwrite, ahb_hmastlock, ahb_hready, ahb_hresp;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi4_to_ahb #(.TAG(TAG)) dut (
    .clk(clk), .rst(rst), .bus_clk_en(bus_clk_en),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awsize(axi_awsize),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arsize(axi_arsize),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .ahb_haddr(ahb_haddr), .ahb_hsize(ahb_hsize), .ahb_htrans(ahb_htrans), .ahb_hwrite(ahb_hwrite),
    .ahb_hwdata(ahb_hwdata), .ahb_hburst(ahb_hburst), .ahb_hprot(ahb_hprot),
    .ahb_hmastlock(ahb_hmastlock), .ahb_hrdata(ahb_hrdata), .ahb_hready(ahb_hready),
    .ahb_hresp(ahb_hresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: access width in bytes, capped at the 8-byte bus.
  function automatic int access_bytes(input logic [2:0] sz);
    int b;
    b = 1;
    for (int i = 0; i < int'(sz); i++) b = b * 2;
    return (b > 8) ? 8 : b;
  endfunction

  function automatic logic [2:0] log2_bytes(input int b);
    logic [2:0] l;
    l = 3'd0;
    while ((1 << l) < b) l = l + 3'd1;
    return l;
  endfunction

  // One complete AXI transaction with the bench acting as AHB slave.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [2:0] sz,
                        input logic [63:0] wd, input logic [TAG-1:0] id, input int waits,
                        input bit err, input int bdly, input bit ar_hold, input bit cont);
    int          bytes    = access_bytes(sz);
    bit          rej      = ALIGN && ((addr % bytes) != 0);
    logic [63:0] sdata    = {$urandom, $urandom};
    logic [1:0]  exp_resp = (rej || err) ? 2'b10 : 2'b00;
    logic [63:0] exp_rd   = rej ? 64'd0 : sdata;
    if (!cont) @(negedge clk);
    if (wr) begin
      axi_awvalid = 1'b1; axi_awaddr = addr; axi_awsize = sz; axi_awid = id;
      axi_wvalid = 1'b1; axi_wdata = wd; axi_wstrb = 8'hFF; axi_arvalid = ar_hold;
    end else begin
      axi_arvalid = 1'b1; axi_araddr = addr; axi_arsize = sz; axi_arid = id;
    end
    ahb_hready = 1'b1; ahb_hresp = 1'b0;
    #1;
    if (wr) begin
      chk("awready", axi_awready, 64'd1);
      chk("wready", axi_wready, 64'd1);
      chk("arready_write_first", axi_arready, 64'd0);
    end else begin
      chk("arready", axi_arready, 64'd1);
    end
    @(negedge clk);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = wr ? ar_hold : 1'b0;
    #1;
    chk("ready_pulse_once", {axi_awready, axi_wready, axi_arready}, 64'd0);
    if (!rej) begin
      chk("htrans_nonseq", ahb_htrans, 64'd2);
      chk("haddr", ahb_haddr, addr);
      chk("hsize", ahb_hsize, log2_bytes(bytes));
      chk("hwrite", ahb_hwrite, wr);
      @(negedge clk); #1;
      chk("htrans_data_idle", ahb_htrans, 64'd0);
      if (wr) chk("hwdata", ahb_hwdata, wd);
      for (int k = 0; k < waits; k++) begin
        ahb_hready = 1'b0; ahb_hresp = err && (k == waits - 1); ahb_hrdata = {$urandom, $urandom};
        @(negedge clk); #1;
        chk("no_resp_during_wait", {axi_bvalid, axi_rvalid}, 64'd0);
        chk("htrans_wait_idle", ahb_htrans, 64'd0);
      end
      ahb_hready = 1'b1; ahb_hresp = err; ahb_hrdata = sdata;
      @(negedge clk);
      ahb_hresp = 1'b0; ahb_hrdata = {$urandom, $urandom};
      #1;
    end else begin
      chk("no_nonseq_misaligned", ahb_htrans, 64'd0);
    end
    for (int j = 0; j <= bdly; j++) begin
      if (wr) begin
        chk("bvalid", axi_bvalid, 64'd1);
        chk("bresp", axi_bresp, exp_resp);
        chk("bid", axi_bid, id);
        chk("rvalid_quiet", axi_rvalid, 64'd0);
      end else begin
        chk("rvalid", axi_rvalid, 64'd1);
        chk("rresp", axi_rresp, exp_resp);
        chk("rid", axi_rid, id);
        chk("rdata", axi_rdata, exp_rd);
        chk("rlast", axi_rlast, 64'd1);
        chk("bvalid_quiet", axi_bvalid, 64'd0);
      end
      chk("htrans_resp_idle", ahb_htrans, 64'd0);
      if (j < bdly) begin
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        axi_bready = 1'b0; axi_rready = 1'b0;
        #1;
        chk("no_accept_while_busy", {axi_awready, axi_wready, axi_arready}, 64'd0);
        @(negedge clk); #1;
      end else begin
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = ar_hold;
        axi_bready = wr; axi_rready = !wr;
        @(negedge clk);
        axi_bready = 1'b0; axi_rready = 1'b0;
        #1;
        chk("resp_retired", {axi_bvalid, axi_rvalid}, 64'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus_clk_en = 1'b1;
    axi_awvalid = 1'b0; axi_awid = '0; axi_awaddr = 32'd0; axi_awsize = 3'd0;
    axi_wvalid = 1'b0; axi_wdata = 64'd0; axi_wstrb = 8'd0; axi_bready = 1'b0;
    axi_arvalid = 1'b0; axi_arid = '0; axi_araddr = 32'd0; axi_arsize = 3'd0; axi_rready = 1'b0;
    ahb_hrdata = 64'd0; ahb_hready = 1'b1; ahb_hresp = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_readies", {axi_awready, axi_wready, axi_arready}, 64'd0);
    chk("rst_valids", {axi_bvalid, axi_rvalid}, 64'd0);
    chk("rst_htrans", ahb_htrans, 64'd0);
    chk("rst_haddr", ahb_haddr, 64'd0);
    chk("rst_hsize", ahb_hsize, 64'd0);
    chk("rst_hwdata", ahb_hwdata, 64'd0);
    chk("rst_resp_id", {axi_bresp, axi_rresp, axi_bid, axi_rid}, 64'd0);
    chk("hprot", ahb_hprot, 64'd3);
    chk("hburst_hmastlock", {ahb_hburst, ahb_hmastlock}, 64'd0);
    rst = 1'b0;

    // Test-plan write, zero wait states.
    do_txn(1'b1, 32'hF004_0008, 3'd2, 64'h1122_3344_5566_7788, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    // Test-plan read with two wait states.
    do_txn(1'b0, 32'hEE00_0010, 3'd3, 64'd0, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0);
    // Two-cycle AHB error on a read.
    do_txn(1'b0, 32'h0000_1000, 3'd2, 64'd0, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0);
    // Write error, then bready held low five cycles.
    do_txn(1'b1, 32'h2000_0004, 3'd1, 64'hCAFE_F00D_1234_5678, 1'b0, 3, 1'b1, 5, 1'b0, 1'b0);
    // AW, W and AR together: write first, read right after the B handshake.
    do_txn(1'b1, 32'h3000_0000, 3'd3, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 0, 1'b0, 2, 1'b1, 1'b0);
    do_txn(1'b0, 32'h3000_0000, 3'd3, 64'd0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
    // Word write at an offset of 2: issued or rejected depending on the build.
    do_txn(1'b1, 32'h4000_0002, 3'd2, 64'h0000_0000_DEAD_0002, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h4000_0001, 3'd1, 64'd0, 1'b1, 1, 1'b0, 1, 1'b0, 1'b0);

    // A frozen bus clock enable blocks acceptance.
    @(negedge clk);
    bus_clk_en = 1'b0; axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("clk_en_low_no_ready", {axi_awready, axi_wready, axi_arready}, 64'd0);
      chk("clk_en_low_no_ahb", ahb_htrans, 64'd0);
      @(negedge clk);
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0; bus_clk_en = 1'b1;

    // Reset during the data phase aborts the write with no response.
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_awaddr = 32'h5000_0010; axi_awsize = 3'd3;
    @(negedge clk);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1; ahb_hready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_htrans", ahb_htrans, 64'd0);
    chk("abort_haddr", ahb_haddr, 64'd0);
    ahb_hready = 1'b1;
    @(negedge clk); #1;
    chk("abort_no_resp", {axi_bvalid, axi_rvalid}, 64'd0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      bit         wr;
      int         waits;
      bit         err;
      wr    = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      err   = (waits > 0) && ($urandom_range(0, 2) == 0);
      do_txn(wr, $urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             waits, err, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_to_ahb.md
Name: axi4_to_ahb

Overview:
- AXI4 slave to AHB-Lite master bridge; the reverse direction of the AHB-to-AXI4 gasket.
- Lets a core-side AXI4 master (LSU/IFU/DMA port) reach an AHB-Lite fabric.
- Single outstanding transaction, single-beat only (len=0), 64-bit data.
- Converts one AXI read or write into one AHB NONSEQ transfer, then returns R or B with mapped error status.

Parameters:
- TAG, 1: AXI ID width. IDs are echoed on bid/rid.

Ports:
- clk  in  1  bridge clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- bus_clk_en  in  1  AHB-side cycle qualifier; state advances only when high
- axi_awvalid  in  1; axi_awready  out  1; axi_awid  in  TAG; axi_awaddr  in  32; axi_awsize  in  3
- axi_wvalid  in  1; axi_wready  out  1; axi_wdata  in  64; axi_wstrb  in  8
- axi_bvalid  out  1; axi_bready  in  1; axi_bresp  out  2; axi_bid  out  TAG
- axi_arvalid  in  1; axi_arready  out  1; axi_arid  in  TAG; axi_araddr  in  32; axi_arsize  in  3
- axi_rvalid  out  1; axi_rready  in  1; axi_rid  out  TAG; axi_rdata  out  64; axi_rresp  out  2; axi_rlast  out  1 (tied 1)
- ahb_haddr  out  32; ahb_hsize  out  3; ahb_htrans  out  2; ahb_hwrite  out  1; ahb_hwdata  out  64
- ahb_hburst  out  3 (0); ahb_hprot  out  4 (4'b0011); ahb_hmastlock  out  1 (0)
- ahb_hrdata  in  64; ahb_hready  in  1; ahb_hresp  in  1

Behaviour:
- Reset (sync, rst=1):
  - All valid/ready outputs 0.
  - ahb_htrans=IDLE (2'b00); haddr, hsize, hwdata, resp and ID registers 0.
  - State=IDLE. rst mid-transfer aborts with no B/R issued.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, WR_RESP, RD_RESP. Transitions occur only when bus_clk_en=1.
- Acceptance in IDLE:
  - Write when awvalid&wvalid are both high. awready and wready pulse together for one cycle; addr, size, id and data are captured.
  - Otherwise read when arvalid: arready pulses, command captured.
  - Write has fixed priority when both are pending.
  - AW without W (or W without AW) is not accepted; the bridge waits.
- WR_ADDR / RD_ADDR:
  - Drive htrans=NONSEQ, haddr, hsize, hwrite.
  - Advance to the *_DATA state when ahb_hready=1.
- WR_DATA:
  - Drive htrans=IDLE; hwdata holds the captured wdata.
  - On hready=1, go to WR_RESP.
- RD_DATA:
  - On hready=1, capture hrdata, go to RD_RESP.
- Error latching:
  - Latch error when hresp=1 in a data phase. Completion occurs on the second cycle, with hready=1.
  - The first error cycle (hready=0) does not complete the transfer.
- Response states:
  - WR_RESP: bvalid=1 with bresp = err ? 2'b10 (SLVERR) : 2'b00. Held until bready; then IDLE.
  - RD_RESP: rvalid=1 with rresp likewise and rdata = captured hrdata. Held until rready; then IDLE.
  - Response payload is stable while valid and not ready.
- Latency: accept → AHB address: 1 cycle; minimum accept → bvalid/rvalid = 3 cycles with zero-wait AHB.
- Width rules:
  - hsize = {0, axsize[1:0]}; axsize[2]=1 is treated as 3'b011.
  - wstrb is not forwarded; the AHB slave uses haddr/hsize.
- bus_clk_en=0: all registers hold and outputs stay stable; ready pulses are not generated.
- No new AXI command is accepted while any state other than IDLE is active.

Optional Feature:
- Macro: AXI4_TO_AHB_ALIGN_CHK_EN.
- Defined:
  - A misaligned command is never issued on AHB. Misaligned means halfword with addr[0], word with |addr[1:0], or dword with |addr[2:0].
  - FSM goes directly from IDLE to WR_RESP/RD_RESP with SLVERR; rdata=0.
- Undefined: no check; the command is forwarded as is, and the AHB slave decides.

Decomposition:
- eh2_pkg additions:
  - axi2ahb_state_t enum (3 bits).
  - localparams HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
- Flops use the existing rvdff*/rvdffe primitives.
- One natural sub-module: axi4_to_ahb_cmdbuf, the single-entry command/response holding register (addr, size, write, id, wdata, rdata, err) with load/clear.

Test Plan:
- Write 0xF004_0008, size 2, wdata 0x1122_3344_5566_7788, id 1, zero-wait AHB → one NONSEQ at 0xF0040008, hsize=2, hwrite=1; hwdata presented the following cycle; bvalid=1, bresp=00, bid=1 on cycle 3.
- Read 0xEE00_0010, size 3, slave inserts 2 wait states and returns 0xDEAD_BEEF_0BAD_F00D → rvalid after the waits, rdata matches, rresp=00, rlast=1.
- Read with AHB error response (hresp=1 & hready=0, then hresp=1 & hready=1) → rresp=10, single completion, bridge returns to IDLE.
- AW, W and AR all valid in the same cycle → write accepted first; arready stays 0 until bvalid&bready handshake; then the read is issued.
- bready held low 5 cycles → bvalid/bresp/bid stable; no new awready meanwhile.
- With AXI4_TO_AHB_ALIGN_CHK_EN: word write at 0x...02 → no NONSEQ on AHB, bresp=10. Without the macro → NONSEQ issued at 0x...02.
